pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the five-stage pipeline. Drives the enable and flush/valid
//  controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
//  Resolves load-use hazards, taken-branch flushes and a req/ack data-memory handshake
//  with a wait timeout. Sits beside the datapath; the stage registers consume its outputs.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max MEM_WAIT cycles before timeout_err; 0 = timeout disabled
//  CNT_W           8   width of the wait counter; must hold TIMEOUT_CYCLES
// PORTS
//  sys_clk          in   1   clock, rising edge
//  sys_rst          in   1   reset, asynchronous, active-low
//  id_rs1           in   5   rs1 index of the instruction in ID
//  id_rs2           in   5   rs2 index of the instruction in ID
//  id_uses_rs1      in   1   ID instruction reads rs1
//  id_uses_rs2      in   1   ID instruction reads rs2
//  ex_rd            in   5   destination register of the instruction in EX
//  ex_is_load       in   1   EX instruction is a load (wb_select = memory)
//  ex_branch_taken  in   1   EX resolved a taken branch/jump
//  mem_access       in   1   MEM-stage instruction reads or writes dmem
//  dmem_ack         in   1   dmem completes the access this cycle
//  dmem_req         out  1   dmem request, held until ack
//  pc_en            out  1   PC register update enable
//  ifid_en          out  1   IF/ID register load enable
//  ifid_flush       out  1   IF/ID loads a bubble (valid = 0)
//  idex_en          out  1   ID/EX register load enable
//  idex_flush       out  1   ID/EX loads a bubble
//  exmem_en         out  1   EX/MEM register load enable
//  memwb_valid      out  1   MEM/WB captures a valid instruction (0 = bubble)
//  timeout_err      out  1   sticky dmem timeout flag
// BEHAVIOUR
//  - States: RUN, MEM_WAIT, ERR. state, wait_cnt and timeout_err are registered; all other outputs are combinational from state and inputs.
//  - Reset (sys_rst = 0, async): state = RUN, wait_cnt = 0, timeout_err = 0.
//    While reset is asserted, dmem_req, all enables, flushes and memwb_valid = 0.
//  - dmem_req = mem_access in RUN; 1 in MEM_WAIT; 0 in ERR.
//  - RUN with mem_access && !dmem_ack: go to MEM_WAIT at the next edge. Memory stall is active this cycle.
//  - Memory stall (RUN with mem_access && !dmem_ack, or any MEM_WAIT cycle without ack):
//    pc_en = ifid_en = idex_en = exmem_en = 0, memwb_valid = 0, no flushes.
//  - Memory stall has highest priority. A flush or load-use bubble is deferred, because the frozen stages hold their inputs stable.
//  - MEM_WAIT with dmem_ack: go to RUN. That cycle all enables are 1 and memwb_valid = 1, so a 1-cycle-ack access costs 1 stall cycle.
//    Zero-wait access (ack in the same cycle as the RUN request) costs 0 stall cycles.
//  - wait_cnt clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
//    With TIMEOUT_CYCLES != 0, when wait_cnt reaches TIMEOUT_CYCLES-1 without ack:
//    go to ERR and set timeout_err = 1.
//  - ERR: all enables 0, dmem_req 0; leave only by reset. timeout_err stays set (sticky).
//  - Taken branch (no memory stall): ifid_flush = 1 and idex_flush = 1; all enables 1.
//    Overrides load-use, because the hazarding ID instruction is squashed.
//  - Load-use (no memory stall, no branch): condition is ex_is_load && ex_rd != 0
//    && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
//    Response: pc_en = 0, ifid_en = 0, idex_flush = 1, exmem_en = 1. Lasts exactly 1 cycle, because the load leaves EX.
//  - Default: all enables 1, no flushes, memwb_valid = 1.
//  - A flush has effect only when the matching enable is 1. The flush wins over the loaded data.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined:
//    - adds output stall_cycles [31:0], reset to 0.
//    - increments every cycle that pc_en = 0 while sys_rst = 1 and state != ERR.
//    - saturates at 32'hFFFF_FFFF.
//  PIPE_CTRL_PERF_EN undefined: the port and counter are absent; the rest of the behaviour is identical.
// TESTING
//  - Reset: sys_rst low mid-MEM_WAIT -> state RUN; dmem_req = 0 and timeout_err = 0 immediately, without a clock edge.
//  - Load-use: ex_is_load = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 ->
//    one cycle of pc_en = 0, ifid_en = 0, idex_flush = 1; next cycle all enables 1.
//  - Load with ex_rd = 0 matching id_rs1 = 0 -> no stall.
//  - Branch plus load-use in the same cycle -> ifid_flush = 1, idex_flush = 1, pc_en = 1.
//  - mem_access = 1 with ack 3 cycles later -> dmem_req high 4 cycles and 3 stall cycles;
//    memwb_valid = 0 during the stall, = 1 on the ack cycle.
//  - TIMEOUT_CYCLES = 4, no ack -> timeout_err rises after 4 MEM_WAIT cycles;
//    dmem_req = 0 and all enables 0 until reset.
//    With PIPE_CTRL_PERF_EN defined, stall_cycles matches the count of pc_en = 0 cycles.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, branch flushes and a
// dmem req/ack wait with timeout. Optional stall counter enabled by macro PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_access,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_valid,
  output logic        timeout_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             load_use, mem_stall, timeout_hit;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign mem_stall = ((state_q == RUN) && mem_access && !dmem_ack) ||
                     ((state_q == MEM_WAIT) && !dmem_ack);

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == MEM_WAIT) && !dmem_ack &&
                       (wait_cnt_q == WAIT_LAST);

  // NOTE: non-blocking assignments in clocked processes so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      RUN: begin
        if (mem_access && !dmem_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_d = RUN;
        end else if (timeout_hit) begin
          state_d       = ERR;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  // Memory stall outranks branch, which outranks load-use; reset forces everything quiet.
  always_comb begin
    dmem_req    = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    memwb_valid = 1'b0;
    if (sys_rst && (state_q != ERR)) begin
      dmem_req = (state_q == MEM_WAIT) || mem_access;
      if (!mem_stall) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_valid = 1'b1;
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  assign timeout_err = timeout_err_q;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      stall_cycles <= '0;
    end else if (!pc_en && (state_q != ERR) && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver pushes hand-computed control words,
// a monitor pops and compares them mid-cycle.
module tb_pipe_hazard_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken, mem_access, dmem_ack;
  logic        dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic        memwb_valid, timeout_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 sys_clk = ~sys_clk;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_access      (mem_access),
    .dmem_ack        (dmem_ack),
    .dmem_req        (dmem_req),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_flush      (idex_flush),
    .exmem_en        (exmem_en),
    .memwb_valid     (memwb_valid),
    .timeout_err     (timeout_err)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  // {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_valid, timeout_err}
  localparam logic [8:0] C_DEF = 9'b011010110;
  localparam logic [8:0] C_LU  = 9'b000011110;
  localparam logic [8:0] C_BR  = 9'b011111110;
  localparam logic [8:0] C_ST  = 9'b100000000;
  localparam logic [8:0] C_AK  = 9'b111010110;
  localparam logic [8:0] C_ER  = 9'b000000001;
  localparam logic [8:0] C_Z   = 9'b000000000;

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] stall;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] perf_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic vec(input string name, input logic rst,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                     input logic [4:0] rd, input logic ld, input logic br,
                     input logic ma, input logic ack, input logic [8:0] ctl);
    exp_t e;
    @(posedge sys_clk);
    #1;
    sys_rst         = rst;
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_uses_rs1     = u1;
    id_uses_rs2     = u2;
    ex_rd           = rd;
    ex_is_load      = ld;
    ex_branch_taken = br;
    mem_access      = ma;
    dmem_ack        = ack;
    if (!rst) perf_cnt = '0;
    e.ctl   = ctl;
    e.stall = perf_cnt;
    e.name  = name;
    exp_q.push_back(e);
    // A cycle with pc_en low outside ERR and reset is counted at the next edge.
    if (rst && !ctl[7] && !ctl[0]) perf_cnt = perf_cnt + 32'd1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {23'b0, dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                       exmem_en, memwb_valid, timeout_err}, {23'b0, e.ctl});
`ifdef PIPE_CTRL_PERF_EN
        check({e.name, "_stall"}, stall_cycles, e.stall);
`endif
      end
    end
  end

  initial begin : driver
    sys_rst = 1'b0;
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken, mem_access, dmem_ack} = '0;

    //   name            rst rs1 rs2 u1 u2 rd  ld br ma ack expected
    vec("rst_hold",      0,  0,  0,  0, 0, 0,  0, 0, 1, 0,  C_Z);
    vec("run_idle",      1,  1,  2,  1, 1, 3,  0, 0, 0, 0,  C_DEF);
    vec("load_use_rs2",  1,  3,  5,  1, 1, 5,  1, 0, 0, 0,  C_LU);
    vec("after_load",    1,  3,  5,  1, 1, 5,  0, 0, 0, 0,  C_DEF);
    vec("load_x0",       1,  0,  7,  1, 1, 0,  1, 0, 0, 0,  C_DEF);
    vec("rs1_unused",    1,  5,  6,  0, 1, 5,  1, 0, 0, 0,  C_DEF);
    vec("branch_lu",     1,  5,  0,  1, 0, 5,  1, 1, 0, 0,  C_BR);
    vec("mem_req",       1,  0,  0,  0, 0, 0,  0, 0, 1, 0,  C_ST);
    vec("mem_wait0_lu",  1,  3,  5,  1, 1, 5,  1, 0, 1, 0,  C_ST);
    vec("mem_wait1_br",  1,  0,  0,  0, 0, 0,  0, 1, 1, 0,  C_ST);
    vec("mem_ack",       1,  0,  0,  0, 0, 0,  0, 0, 1, 1,  C_AK);
    vec("zero_wait",     1,  0,  0,  0, 0, 0,  0, 0, 1, 1,  C_AK);
    vec("post_zero",     1,  0,  0,  0, 0, 0,  0, 0, 0, 0,  C_DEF);
    vec("to_req",        1,  0,  0,  0, 0, 0,  0, 0, 1, 0,  C_ST);
    for (int i = 0; i < 4; i++)
      vec($sformatf("to_wait%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ST);
    vec("err0",          1,  0,  0,  0, 0, 0,  0, 0, 1, 0,  C_ER);
    vec("err_ack_br",    1,  0,  0,  0, 0, 0,  0, 1, 1, 1,  C_ER);
    vec("rst_in_err",    0,  0,  0,  0, 0, 0,  0, 0, 1, 0,  C_Z);
    vec("rst_release",   1,  0,  0,  0, 0, 0,  0, 0, 0, 0,  C_DEF);
    vec("mw_req",        1,  0,  0,  0, 0, 0,  0, 0, 1, 0,  C_ST);
    vec("mw_wait0",      1,  0,  0,  0, 0, 0,  0, 0, 1, 0,  C_ST);
    vec("rst_mid_wait",  0,  0,  0,  0, 0, 0,  0, 0, 1, 0,  C_Z);
    vec("after_rst",     1,  0,  0,  0, 0, 0,  0, 0, 0, 0,  C_DEF);

    @(posedge sys_clk);
    @(negedge sys_clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
